// File: rtl/ohc11_adder_rr_sched.sv
// Round-robin scheduler sharing one one-hot mod-11 adder between N_REQ requesters,
// with a one-entry output buffer. Optional operand check: OHC_ONEHOT_CHECK_EN.
module ohc11_adder_rr_sched #(
    parameter int N_REQ = 4,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [11*N_REQ-1:0]   a_ohc,
    input  logic [11*N_REQ-1:0]   b_ohc,
    output logic [N_REQ-1:0]      gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10:0]           out_ohc,
    output logic [3:0]            out_bin,
    output logic [IDW-1:0]        out_id,
    output logic                  err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t      state, state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic            grant;
    logic            can_accept;
    logic [10:0]     sel_a, sel_b, sum_ohc;
    logic [3:0]      sum_bin;
    logic [21:0]     dbl;

    assign out_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) || out_ready;

    // Search starts one past the last winner and wraps modulo N_REQ.
    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_idx = '0;
        grant   = 1'b0;
        idx     = 0;
        if (can_accept) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                idx = (32'(ptr) + k) % N_REQ;
                if (!grant && req[idx]) begin
                    grant   = 1'b1;
                    gnt_idx = IDW'(idx);
                end
            end
        end
        if (grant) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = sel_a | a_ohc[11*i +: 11];
                sel_b = sel_b | b_ohc[11*i +: 11];
            end
        end
    end

    // Rotating A left by j (the set bit of B) adds j mod 11; the doubled word supplies the wrap.
    always_comb begin
        sum_ohc = '0;
        dbl     = '0;
        for (int unsigned j = 0; j < 11; j++) begin
            if (sel_b[j]) begin
                dbl     = {sel_a, sel_a} << j;
                sum_ohc = sum_ohc | dbl[21:11];
            end
        end
    end

    always_comb begin
        sum_bin = 4'd0;
        for (int unsigned k = 0; k < 11; k++) begin
            if (sum_ohc[k]) sum_bin = 4'(k);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (grant) state_next = FULL;
            FULL:    if (out_ready && !grant) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

`ifdef OHC_ONEHOT_CHECK_EN
    function automatic logic is_onehot(input logic [10:0] v);
        return (v != '0) && ((v & (v - 11'd1)) == '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= IDW'(N_REQ - 1);
            out_ohc <= 11'b00000000001;
            out_bin <= 4'd0;
            out_id  <= '0;
            err     <= 1'b0;
        end else if (grant) begin
            ptr    <= gnt_idx;
            out_id <= gnt_idx;
            if (!is_onehot(sel_a) || !is_onehot(sel_b)) begin
                out_ohc <= '0;
                out_bin <= 4'hF;
                err     <= 1'b1;
            end else begin
                out_ohc <= sum_ohc;
                out_bin <= sum_bin;
                err     <= 1'b0;
            end
        end
    end
`else
    assign err = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= IDW'(N_REQ - 1);
            out_ohc <= 11'b00000000001;
            out_bin <= 4'd0;
            out_id  <= '0;
        end else if (grant) begin
            ptr     <= gnt_idx;
            out_id  <= gnt_idx;
            out_ohc <= sum_ohc;
            out_bin <= sum_bin;
        end
    end
`endif

endmodule

// File: tb/tb_ohc11_adder_rr_sched.sv
// Scoreboard bench for ohc11_adder_rr_sched: directed vectors push expected results,
// a monitor pops and compares on each output handshake.
module tb_ohc11_adder_rr_sched;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [11*N-1:0]   a_ohc = '0;
    logic [11*N-1:0]   b_ohc = '0;
    logic [N-1:0]      gnt;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [10:0]       out_ohc;
    logic [3:0]        out_bin;
    logic [1:0]        out_id;
    logic              err;

    typedef struct {
        logic [10:0] ohc;
        logic [3:0]  bin;
        logic [1:0]  id;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    ohc11_adder_rr_sched #(.N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_ohc(a_ohc), .b_ohc(b_ohc),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_ohc(out_ohc), .out_bin(out_bin), .out_id(out_id), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act === req_v) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req_v);
    endtask

    task automatic set_raw(input int i, input logic [10:0] a, input logic [10:0] b);
        a_ohc[i*11 +: 11] = a;
        b_ohc[i*11 +: 11] = b;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        set_raw(i, 11'd1 << a, 11'd1 << b);
    endtask

    // One cycle: drive, check grant before the edge, enqueue the expected result.
    task automatic step(input logic [N-1:0] r, input logic rdy, input logic [N-1:0] exp_gnt,
                        input int exp_bin, input int exp_id, input logic exp_err);
        exp_t e;
        req       = r;
        out_ready = rdy;
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        if (exp_gnt != '0) begin
            e.bin = 4'(exp_bin);
            e.ohc = (exp_bin == 15) ? 11'd0 : (11'd1 << exp_bin);
            e.id  = 2'(exp_id);
            e.err = exp_err;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ohc",   32'(out_ohc),   32'd1);
        check("rst_bin",   32'(out_bin),   32'd0);
        check("rst_id",    32'(out_id),    32'd0);
        check("rst_err",   32'(err),       32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_bin), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("out_ohc", 32'(out_ohc), 32'(e.ohc));
                    check("out_bin", 32'(out_bin), 32'(e.bin));
                    check("out_id",  32'(out_id),  32'(e.id));
                    check("err",     32'(err),     32'(e.err));
                end
            end
        end
    end

    initial begin : driver
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic sum and mod-11 wrap cases
        set_op(0, 3, 4);   step(4'b0001, 1'b1, 4'b0001, 7, 0, 1'b0);
        set_op(0, 9, 5);   step(4'b0001, 1'b1, 4'b0001, 3, 0, 1'b0);
        set_op(0, 10, 10); step(4'b0001, 1'b1, 4'b0001, 9, 0, 1'b0);
        set_op(0, 0, 0);   step(4'b0001, 1'b1, 4'b0001, 0, 0, 1'b0);

        // requester i yields (i+2+10) mod 11 = i+1
        for (int i = 0; i < N; i++) set_op(i, i + 2, 10);
        step(4'b1000, 1'b1, 4'b1000, 4, 3, 1'b0);
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, 1'b1, 4'b0001, 1, 0, 1'b0);
            step(4'b1111, 1'b1, 4'b0010, 2, 1, 1'b0);
            step(4'b1111, 1'b1, 4'b0100, 3, 2, 1'b0);
            step(4'b1111, 1'b1, 4'b1000, 4, 3, 1'b0);
        end
        step(4'b0000, 1'b1, 4'b0000, 0, 0, 1'b0);

        // backpressure: held output, no grant, then drain and grant on the same edge
        step(4'b0001, 1'b1, 4'b0001, 1, 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(4'b0010, 1'b0, 4'b0000, 0, 0, 1'b0);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_id",    32'(out_id),    32'd0);
            check("hold_bin",   32'(out_bin),   32'd1);
            check("hold_ohc",   32'(out_ohc),   32'd2);
        end
        step(4'b0010, 1'b1, 4'b0010, 2, 1, 1'b0);

        // pointer wrap
        step(4'b1010, 1'b1, 4'b1000, 4, 3, 1'b0);
        step(4'b1010, 1'b1, 4'b0010, 2, 1, 1'b0);

        // reset while FULL discards the buffered result
        step(4'b0000, 1'b0, 4'b0000, 0, 0, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check_reset_vals();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // pointer back at N-1: requester 0 beats requester 2
        set_op(0, 2, 10);
        step(4'b0101, 1'b1, 4'b0001, 1, 0, 1'b0);

`ifdef OHC_ONEHOT_CHECK_EN
        set_raw(0, 11'b00000000110, 11'd1 << 4);
        step(4'b0001, 1'b1, 4'b0001, 15, 0, 1'b1);
        set_raw(0, 11'd1 << 3, 11'd0);
        step(4'b0001, 1'b1, 4'b0001, 15, 0, 1'b1);
        set_op(0, 3, 4);
        step(4'b0001, 1'b1, 4'b0001, 7, 0, 1'b0);
`endif

        // drain with a bounded wait
        for (int c = 0; c < 10 && exp_q.size() != 0; c++)
            step(4'b0000, 1'b1, 4'b0000, 0, 0, 1'b0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
